// File: rtl/rb_access_arbiter_if.sv
// Regbank write and read channel interfaces shared by the requesters, the arbiter and the regbank.
// The master drives the strobe and the fields; on the read channel the slave answers with data and valid.
interface reg_wrchan_if;
   logic [7:0]  addr;
   logic [15:0] data;
   logic [1:0]  bmask;
   logic        write;

   modport master (output addr, output data, output bmask, output write);
   modport slave  (input addr, input data, input bmask, input write);
endinterface

interface reg_rdchan_if;
   logic [7:0]  addr;
   logic        read;
   logic [15:0] data;
   logic        valid;

   modport master (output addr, output read, input data, input valid);
   modport slave  (input addr, input read, output data, output valid);
endinterface

// File: rtl/rb_access_arbiter.sv
// Two-requester arbiter onto the single regbank write/read channel, with per-requester pending slots.
// Define RB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); otherwise round-robin.
module rb_access_arbiter #(
   parameter int          RD_TIMEOUT   = 16,
   parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   reg_wrchan_if.slave  sif_wr_req0,
   reg_rdchan_if.slave  sif_rd_req0,
   reg_wrchan_if.slave  sif_wr_req1,
   reg_rdchan_if.slave  sif_rd_req1,
   reg_wrchan_if.master mif_wr_rb,
   reg_rdchan_if.master mif_rd_rb,
   output logic         o_busy,
   output logic [1:0]   o_ovf,
   output logic         o_rd_timeout,
   output logic [1:0]   o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WR      = 2'd1,
      S_RD_WAIT = 2'd2
   } state_t;

   state_t      state_q, state_d;

   // Handshake: write/read are single-cycle strobes with no ready; valid is a one-cycle response pulse.
   logic [1:0]  wr_stb, rd_stb;
   logic [7:0]  wr_addr_in  [2];
   logic [15:0] wr_data_in  [2];
   logic [1:0]  wr_bmask_in [2];
   logic [7:0]  rd_addr_in  [2];

   logic [1:0]  wr_pend_q, rd_pend_q, pend;
   logic [7:0]  wr_addr_q  [2];
   logic [15:0] wr_data_q  [2];
   logic [1:0]  wr_bmask_q [2];
   logic [7:0]  rd_addr_q  [2];
   logic [1:0]  ovf_q;

   logic        sel;
   logic [1:0]  grant_wr, grant_rd;
   logic        txn_req_q;
   logic [7:0]  txn_addr_q;
   logic [15:0] txn_data_q;
   logic [1:0]  txn_bmask_q;
   logic [7:0]  tmo_cnt_q;
   logic        tmo_hit;
   logic [1:0]  ret_vld_q;
   logic [15:0] ret_data_q [2];
   logic        tmo_q;

   assign wr_stb         = {sif_wr_req1.write, sif_wr_req0.write};
   assign rd_stb         = {sif_rd_req1.read, sif_rd_req0.read};
   assign wr_addr_in[0]  = sif_wr_req0.addr;
   assign wr_addr_in[1]  = sif_wr_req1.addr;
   assign wr_data_in[0]  = sif_wr_req0.data;
   assign wr_data_in[1]  = sif_wr_req1.data;
   assign wr_bmask_in[0] = sif_wr_req0.bmask;
   assign wr_bmask_in[1] = sif_wr_req1.bmask;
   assign rd_addr_in[0]  = sif_rd_req0.addr;
   assign rd_addr_in[1]  = sif_rd_req1.addr;

   assign pend = wr_pend_q | rd_pend_q;

`ifdef RB_ARB_FIXED_PRIO_EN
   assign sel = ~pend[0];
`else
   logic ptr_q;
   assign sel = (&pend) ? ptr_q : ~pend[0];
`endif

   // A pending valid wins over the timeout in the last waiting cycle.
   assign tmo_hit = (state_q == S_RD_WAIT) && !mif_rd_rb.valid &&
                    (tmo_cnt_q == 8'(RD_TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      grant_wr = 2'b00;
      grant_rd = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (|pend) begin
               if (wr_pend_q[sel]) begin
                  grant_wr[sel] = 1'b1;
                  state_d       = S_WR;
               end else begin
                  grant_rd[sel] = 1'b1;
                  state_d       = S_RD_WAIT;
               end
            end
         end
         S_WR:      state_d = S_IDLE;
         S_RD_WAIT: if (mif_rd_rb.valid || tmo_hit) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         wr_pend_q   <= 2'b00;
         rd_pend_q   <= 2'b00;
         ovf_q       <= 2'b00;
         txn_req_q   <= 1'b0;
         txn_addr_q  <= 8'h00;
         txn_data_q  <= 16'h0000;
         txn_bmask_q <= 2'b00;
         tmo_cnt_q   <= 8'h00;
         ret_vld_q   <= 2'b00;
         tmo_q       <= 1'b0;
`ifndef RB_ARB_FIXED_PRIO_EN
         ptr_q       <= 1'b0;
`endif
         for (int r = 0; r < 2; r++) begin
            wr_addr_q[r]  <= 8'h00;
            wr_data_q[r]  <= 16'h0000;
            wr_bmask_q[r] <= 2'b00;
            rd_addr_q[r]  <= 8'h00;
            ret_data_q[r] <= 16'h0000;
         end
      end else begin
         state_q   <= state_d;
         ret_vld_q <= 2'b00;
         tmo_q     <= 1'b0;

         // The slot being granted this cycle is free to take a new strobe.
         for (int r = 0; r < 2; r++) begin
            if (wr_stb[r] && (!wr_pend_q[r] || grant_wr[r])) begin
               wr_pend_q[r]  <= 1'b1;
               wr_addr_q[r]  <= wr_addr_in[r];
               wr_data_q[r]  <= wr_data_in[r];
               wr_bmask_q[r] <= wr_bmask_in[r];
            end else if (grant_wr[r]) begin
               wr_pend_q[r] <= 1'b0;
            end
            if (rd_stb[r] && (!rd_pend_q[r] || grant_rd[r])) begin
               rd_pend_q[r] <= 1'b1;
               rd_addr_q[r] <= rd_addr_in[r];
            end else if (grant_rd[r]) begin
               rd_pend_q[r] <= 1'b0;
            end
            if ((wr_stb[r] && wr_pend_q[r] && !grant_wr[r]) ||
                (rd_stb[r] && rd_pend_q[r] && !grant_rd[r]))
               ovf_q[r] <= 1'b1;
         end

         if (|grant_wr) begin
            txn_req_q   <= sel;
            txn_addr_q  <= wr_addr_q[sel];
            txn_data_q  <= wr_data_q[sel];
            txn_bmask_q <= wr_bmask_q[sel];
         end else if (|grant_rd) begin
            txn_req_q  <= sel;
            txn_addr_q <= rd_addr_q[sel];
         end
`ifndef RB_ARB_FIXED_PRIO_EN
         if (|{grant_wr, grant_rd}) ptr_q <= ~sel;
`endif

         if (|grant_rd)
            tmo_cnt_q <= 8'h00;
         else if (state_q == S_RD_WAIT)
            tmo_cnt_q <= tmo_cnt_q + 8'd1;

         if (state_q == S_RD_WAIT && mif_rd_rb.valid) begin
            ret_vld_q[txn_req_q]  <= 1'b1;
            ret_data_q[txn_req_q] <= mif_rd_rb.data;
         end else if (tmo_hit) begin
            ret_vld_q[txn_req_q]  <= 1'b1;
            ret_data_q[txn_req_q] <= TIMEOUT_DATA;
            tmo_q                 <= 1'b1;
         end
      end
   end

   assign mif_wr_rb.write = (state_q == S_WR);
   assign mif_wr_rb.addr  = txn_addr_q;
   assign mif_wr_rb.data  = txn_data_q;
   assign mif_wr_rb.bmask = txn_bmask_q;
   assign mif_rd_rb.read  = (state_q == S_RD_WAIT) && (tmo_cnt_q == 8'h00);
   assign mif_rd_rb.addr  = txn_addr_q;

   assign sif_rd_req0.valid = ret_vld_q[0];
   assign sif_rd_req0.data  = ret_data_q[0];
   assign sif_rd_req1.valid = ret_vld_q[1];
   assign sif_rd_req1.data  = ret_data_q[1];

   assign o_busy       = (state_q != S_IDLE) || (|pend);
   assign o_ovf        = ovf_q;
   assign o_rd_timeout = tmo_q;
   assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_rb_access_arbiter.sv
// Self-checking bench for rb_access_arbiter: scoreboard of downstream transactions and read returns.
module tb_rb_access_arbiter;

   logic clk;
   logic rst_n;

   reg_wrchan_if wr0 ();
   reg_rdchan_if rd0 ();
   reg_wrchan_if wr1 ();
   reg_rdchan_if rd1 ();
   reg_wrchan_if wr_rb ();
   reg_rdchan_if rd_rb ();

   logic       o_busy;
   logic [1:0] o_ovf;
   logic       o_rd_timeout;
   logic [1:0] o_dbg_state;

   rb_access_arbiter #(.RD_TIMEOUT(16), .TIMEOUT_DATA(16'hDEAD)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .sif_wr_req0  (wr0),
      .sif_rd_req0  (rd0),
      .sif_wr_req1  (wr1),
      .sif_rd_req1  (rd1),
      .mif_wr_rb    (wr_rb),
      .mif_rd_rb    (rd_rb),
      .o_busy       (o_busy),
      .o_ovf        (o_ovf),
      .o_rd_timeout (o_rd_timeout),
      .o_dbg_state  (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard state ----------------
   logic [26:0] exp_ds_q [$];   // {is_read, addr, data, bmask}
   logic [17:0] exp_ret_q [$];  // {timeout, requester, data}
   int n_tests = 0;
   int n_fail  = 0;
   int last_wr_cyc = 0;
   int last_rd_cyc = 0;
   int last_ret_cyc = 0;
   int ret_cnt = 0;

   // ---------------- regbank responder ----------------
   bit          rb_resp_en = 1'b1;
   int          rb_delay   = 1;
   logic [15:0] rb_data    = 16'h0000;
   bit          stray_vld  = 1'b0;
   int          rsp_cd     = 0;

   always @(posedge clk) begin
      if (!rst_n) rsp_cd = 0;
      else if (rsp_cd != 0) rsp_cd--;
      else if (rd_rb.read && rb_resp_en) rsp_cd = rb_delay;
      #1;
      rd_rb.valid = (rsp_cd == 1) || stray_vld;
      rd_rb.data  = ((rsp_cd == 1) || stray_vld) ? rb_data : 16'h0000;
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      logic [26:0] obs, exp;
      if (rst_n && (wr_rb.write || rd_rb.read)) begin
         obs = wr_rb.write ? {1'b0, wr_rb.addr, wr_rb.data, wr_rb.bmask}
                           : {1'b1, rd_rb.addr, 16'h0000, 2'b00};
         if (wr_rb.write) last_wr_cyc = cyc;
         else             last_rd_cyc = cyc;
         n_tests++;
         if (wr_rb.write && rd_rb.read) begin
            n_fail++;
            $display("FAIL ds_overlap: write and read both high at cycle %0d", cyc);
         end else if (exp_ds_q.size() == 0) begin
            n_fail++;
            $display("FAIL ds_unexpected: got %h, expected nothing", obs);
         end else begin
            exp = exp_ds_q.pop_front();
            if (obs !== exp) begin
               n_fail++;
               $display("FAIL ds_txn: got %h, expected %h", obs, exp);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [17:0] obs, exp;
      if (rst_n && (rd0.valid || rd1.valid || o_rd_timeout)) begin
         obs = {o_rd_timeout, rd1.valid, rd1.valid ? rd1.data : rd0.data};
         last_ret_cyc = cyc;
         ret_cnt++;
         n_tests++;
         if (rd0.valid && rd1.valid) begin
            n_fail++;
            $display("FAIL ret_both: both requester valids high at cycle %0d", cyc);
         end else if (exp_ret_q.size() == 0) begin
            n_fail++;
            $display("FAIL ret_unexpected: got %h, expected nothing", obs);
         end else begin
            exp = exp_ret_q.pop_front();
            if (obs !== exp) begin
               n_fail++;
               $display("FAIL ret_data: got %h, expected %h", obs, exp);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wr(input bit r, input logic [7:0] a, input logic [15:0] d, input logic [1:0] m);
      if (r == 1'b0) begin
         wr0.addr = a; wr0.data = d; wr0.bmask = m; wr0.write = 1'b1;
      end else begin
         wr1.addr = a; wr1.data = d; wr1.bmask = m; wr1.write = 1'b1;
      end
   endtask

   task automatic drive_rd(input bit r, input logic [7:0] a);
      if (r == 1'b0) begin
         rd0.addr = a; rd0.read = 1'b1;
      end else begin
         rd1.addr = a; rd1.read = 1'b1;
      end
   endtask

   task automatic idle_inputs();
      wr0.write = 1'b0;
      wr1.write = 1'b0;
      rd0.read  = 1'b0;
      rd1.read  = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      @(negedge clk);
      while ((o_busy || exp_ds_q.size() != 0 || exp_ret_q.size() != 0) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (o_busy || exp_ds_q.size() != 0 || exp_ret_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_idle: busy=%0b ds_left=%0d ret_left=%0d after %0d cycles",
                  o_busy, exp_ds_q.size(), exp_ret_q.size(), max_cyc);
         exp_ds_q.delete();
         exp_ret_q.delete();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [77:0] obs;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      obs = {wr_rb.write, rd_rb.read, wr_rb.addr, wr_rb.data, wr_rb.bmask, rd_rb.addr,
             rd0.valid, rd0.data, rd1.valid, rd1.data, o_busy, o_ovf, o_rd_timeout};
      n_tests++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, expected 0", obs);
      end
      n_tests++;
      if (o_dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %0d, expected 0", o_dbg_state);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (o_busy !== 1'b0 || o_ovf !== 2'b00) begin
         n_fail++;
         $display("FAIL post_reset: busy=%0b ovf=%b, expected 0/00", o_busy, o_ovf);
      end
   endtask

   task automatic test_single_write();
      int k;
      tick();
      k = cyc;
      drive_wr(1'b0, 8'h10, 16'h1234, 2'b11);
      exp_ds_q.push_back({1'b0, 8'h10, 16'h1234, 2'b11});
      tick();
      idle_inputs();
      n_tests++;
      if (o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_pending: got %0b, expected 1", o_busy);
      end
      wait_idle(30);
      n_tests++;
      if (last_wr_cyc !== k + 2) begin
         n_fail++;
         $display("FAIL write_latency: got cycle %0d, expected %0d", last_wr_cyc, k + 2);
      end
      n_tests++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_done: got %0b, expected 0", o_busy);
      end
   endtask

   task automatic test_read_return();
      int k;
      rb_resp_en = 1'b1;
      rb_delay   = 3;
      rb_data    = 16'hBEEF;
      tick();
      k = cyc;
      drive_rd(1'b1, 8'h22);
      exp_ds_q.push_back({1'b1, 8'h22, 16'h0000, 2'b00});
      exp_ret_q.push_back({1'b0, 1'b1, 16'hBEEF});
      tick();
      idle_inputs();
      wait_idle(40);
      n_tests++;
      if (last_rd_cyc !== k + 2) begin
         n_fail++;
         $display("FAIL read_latency: got cycle %0d, expected %0d", last_rd_cyc, k + 2);
      end
      n_tests++;
      if (last_ret_cyc !== last_rd_cyc + 4) begin
         n_fail++;
         $display("FAIL return_latency: got cycle %0d, expected %0d", last_ret_cyc, last_rd_cyc + 4);
      end
   endtask

   task automatic test_alternation();
      for (int i = 0; i < 4; i++) begin
         tick();
         drive_wr(1'b0, 8'(8'h40 + i), 16'(16'hA000 + i), 2'b01);
         drive_wr(1'b1, 8'(8'h80 + i), 16'(16'hB000 + i), 2'b10);
         exp_ds_q.push_back({1'b0, 8'(8'h40 + i), 16'(16'hA000 + i), 2'b01});
         exp_ds_q.push_back({1'b0, 8'(8'h80 + i), 16'(16'hB000 + i), 2'b10});
         tick();
         idle_inputs();
         wait_idle(30);
      end
      // After a lone requester-0 grant, the pointer favours requester 1 in round-robin mode.
      tick();
      drive_wr(1'b0, 8'h50, 16'hC000, 2'b11);
      exp_ds_q.push_back({1'b0, 8'h50, 16'hC000, 2'b11});
      tick();
      idle_inputs();
      wait_idle(30);
      tick();
      drive_wr(1'b0, 8'h51, 16'hC001, 2'b11);
      drive_wr(1'b1, 8'h52, 16'hC002, 2'b11);
`ifdef RB_ARB_FIXED_PRIO_EN
      exp_ds_q.push_back({1'b0, 8'h51, 16'hC001, 2'b11});
      exp_ds_q.push_back({1'b0, 8'h52, 16'hC002, 2'b11});
`else
      exp_ds_q.push_back({1'b0, 8'h52, 16'hC002, 2'b11});
      exp_ds_q.push_back({1'b0, 8'h51, 16'hC001, 2'b11});
`endif
      tick();
      idle_inputs();
      wait_idle(30);
   endtask

   task automatic test_wr_before_rd();
      rb_resp_en = 1'b1;
      rb_delay   = 1;
      rb_data    = 16'h5A5A;
      tick();
      drive_wr(1'b0, 8'h05, 16'h0F0F, 2'b01);
      drive_rd(1'b0, 8'h05);
      exp_ds_q.push_back({1'b0, 8'h05, 16'h0F0F, 2'b01});
      exp_ds_q.push_back({1'b1, 8'h05, 16'h0000, 2'b00});
      exp_ret_q.push_back({1'b0, 1'b0, 16'h5A5A});
      tick();
      idle_inputs();
      wait_idle(30);
      n_tests++;
      if (last_rd_cyc !== last_wr_cyc + 2) begin
         n_fail++;
         $display("FAIL raw_gap: read at %0d, expected %0d", last_rd_cyc, last_wr_cyc + 2);
      end
   endtask

   task automatic test_timeout();
      rb_resp_en = 1'b0;
      tick();
      drive_rd(1'b0, 8'h77);
      exp_ds_q.push_back({1'b1, 8'h77, 16'h0000, 2'b00});
      exp_ret_q.push_back({1'b1, 1'b0, 16'hDEAD});
      tick();
      idle_inputs();
      wait_idle(60);
      n_tests++;
      if (last_ret_cyc !== last_rd_cyc + 16) begin
         n_fail++;
         $display("FAIL timeout_latency: got cycle %0d, expected %0d", last_ret_cyc, last_rd_cyc + 16);
      end
      rb_resp_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      tick();
      drive_wr(1'b0, 8'h11, 16'h1111, 2'b11);
      exp_ds_q.push_back({1'b0, 8'h11, 16'h1111, 2'b11});
      tick();
      drive_wr(1'b0, 8'h12, 16'h2222, 2'b10);
      exp_ds_q.push_back({1'b0, 8'h12, 16'h2222, 2'b10});
      tick();
      idle_inputs();
      wait_idle(30);
      n_tests++;
      if (o_ovf !== 2'b00) begin
         n_fail++;
         $display("FAIL grant_cycle_accept: ovf=%b, expected 00", o_ovf);
      end
   endtask

   task automatic test_overflow();
      rb_resp_en = 1'b1;
      rb_delay   = 6;
      rb_data    = 16'h3333;
      tick();
      drive_rd(1'b0, 8'h30);
      exp_ds_q.push_back({1'b1, 8'h30, 16'h0000, 2'b00});
      exp_ret_q.push_back({1'b0, 1'b0, 16'h3333});
      tick();
      idle_inputs();
      tick();
      drive_wr(1'b1, 8'h60, 16'h6666, 2'b11);
      exp_ds_q.push_back({1'b0, 8'h60, 16'h6666, 2'b11});
      tick();
      idle_inputs();
      tick();
      drive_wr(1'b1, 8'h61, 16'h7777, 2'b01);
      tick();
      idle_inputs();
      wait_idle(40);
      n_tests++;
      if (o_ovf !== 2'b10) begin
         n_fail++;
         $display("FAIL overflow_flag: got %b, expected 10", o_ovf);
      end
   endtask

   task automatic test_reset_mid_read();
      int r0;
      rb_resp_en = 1'b0;
      tick();
      drive_rd(1'b1, 8'h44);
      exp_ds_q.push_back({1'b1, 8'h44, 16'h0000, 2'b00});
      tick();
      idle_inputs();
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      n_tests++;
      if (o_ovf !== 2'b00 || o_busy !== 1'b0 || o_dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_abort: ovf=%b busy=%0b state=%0d, expected 00/0/0", o_ovf, o_busy, o_dbg_state);
      end
      tick();
      rst_n = 1'b1;
      r0 = ret_cnt;
      repeat (25) tick();
      n_tests++;
      if (ret_cnt !== r0) begin
         n_fail++;
         $display("FAIL reset_no_valid: %0d returns after reset, expected 0", ret_cnt - r0);
      end
      n_tests++;
      if (exp_ds_q.size() !== 0) begin
         n_fail++;
         $display("FAIL reset_read_issued: %0d reads left, expected 0", exp_ds_q.size());
         exp_ds_q.delete();
      end
      rb_resp_en = 1'b1;
   endtask

   task automatic test_stray_valid();
      int r0;
      r0 = ret_cnt;
      rb_data = 16'hFFFF;
      tick();
      stray_vld = 1'b1;
      repeat (3) tick();
      stray_vld = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (ret_cnt !== r0) begin
         n_fail++;
         $display("FAIL stray_valid: %0d returns, expected 0", ret_cnt - r0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      wr0.addr = '0; wr0.data = '0; wr0.bmask = '0; wr0.write = 1'b0;
      wr1.addr = '0; wr1.data = '0; wr1.bmask = '0; wr1.write = 1'b0;
      rd0.addr = '0; rd0.read = 1'b0;
      rd1.addr = '0; rd1.read = 1'b0;
      rd_rb.valid = 1'b0;
      rd_rb.data  = '0;
      test_reset();
      test_single_write();
      test_read_return();
      test_alternation();
      test_wr_before_rd();
      test_timeout();
      test_back_to_back();
      test_overflow();
      test_reset_mid_read();
      test_stray_valid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
